// File: rtl/div_round_sat.sv
// Sequential fixed-point divider: restoring division on operand magnitudes,
// STEPS quotient bits per clock, selectable signedness and rounding, optional saturation.
module div_round_sat #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int STEPS = 1,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [1:0]       rmode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int N  = WIDTH + FBITS + 1;
  localparam int CW = $clog2(N + 9);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, INIT, CALC, ROUND, SIGN} state_t;

  state_t           state_reg;
  logic             sgn_reg;
  logic [1:0]       rmode_reg;
  logic             neg_reg;
  logic [WIDTH-1:0] a_mag_reg;
  logic [WIDTH-1:0] b_mag_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [N-1:0]     n_reg;
  logic [N-1:0]     q_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg, done_reg, valid_reg, dbz_reg, ovf_reg;
  logic [WIDTH-1:0] val_reg;

  logic [WIDTH-1:0] a_mag_next, b_mag_next;
  logic [WIDTH-1:0] rem_next;
  logic [N-1:0]     n_next, q_next;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic             inc;
  logic [N-1:0]     r_rnd, lim;
  logic             in_range;
  logic [WIDTH-1:0] res, ovf_sat, dbz_sat;

  always_comb begin
    a_mag_next = (sgn && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    b_mag_next = (sgn && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    dbz_sat    = sgn ? (a[WIDTH-1] ? SMIN : SMAX) : UMAX;
  end

  // Up to STEPS restoring iterations; the last clock may run fewer.
  always_comb begin
    rem_next = rem_reg;
    n_next   = n_reg;
    q_next   = q_reg;
    shifted  = '0;
    ge       = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      if (CW'(i) < cnt_reg) begin
        shifted  = {rem_next, n_next[N-1]};
        ge       = shifted >= {1'b0, b_mag_reg};
        rem_next = ge ? WIDTH'(shifted - {1'b0, b_mag_reg}) : shifted[WIDTH-1:0];
        n_next   = {n_next[N-2:0], 1'b0};
        q_next   = {q_next[N-2:0], ge};
      end
    end
    cnt_next = (cnt_reg > CW'(STEPS)) ? cnt_reg - CW'(STEPS) : '0;
  end

  // q_reg[0] is the guard bit; rounding works on magnitudes.
  always_comb begin
    case (rmode_reg)
      2'd0:    inc = 1'b0;
      2'd2:    inc = q_reg[0];
      default: inc = q_reg[0] & (q_reg[1] | (|rem_reg));
    endcase
    r_rnd = {1'b0, q_reg[N-1:1]} + N'(inc);
    if (!sgn_reg)
      lim = (N'(1) << WIDTH) - N'(1);
    else if (neg_reg)
      lim = N'(1) << (WIDTH - 1);
    else
      lim = (N'(1) << (WIDTH - 1)) - N'(1);
    in_range = r_rnd <= lim;
    res      = neg_reg ? (~r_rnd[WIDTH-1:0]) + WIDTH'(1) : r_rnd[WIDTH-1:0];
    ovf_sat  = neg_reg ? SMIN : (sgn_reg ? SMAX : UMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sgn_reg   <= 1'b0;
      rmode_reg <= 2'd0;
      neg_reg   <= 1'b0;
      a_mag_reg <= '0;
      b_mag_reg <= '0;
      rem_reg   <= '0;
      n_reg     <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
      dbz_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      val_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // SIGN is the done cycle: busy is already low, so a new start is taken here too.
        IDLE, SIGN: begin
          state_reg <= IDLE;
          if (start) begin
            sgn_reg   <= sgn;
            rmode_reg <= rmode;
            a_mag_reg <= a_mag_next;
            b_mag_reg <= b_mag_next;
            neg_reg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            dbz_reg   <= 1'b0;
            if (b == '0) begin
              done_reg <= 1'b1;
              dbz_reg  <= 1'b1;
              if (SAT != 0) val_reg <= dbz_sat;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= INIT;
            end
          end
        end
        INIT: begin
          rem_reg   <= '0;
          n_reg     <= {a_mag_reg, {(FBITS+1){1'b0}}};
          q_reg     <= '0;
          cnt_reg   <= CW'(N);
          state_reg <= CALC;
        end
        CALC: begin
          rem_reg <= rem_next;
          n_reg   <= n_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_next;
          if (cnt_next == '0) state_reg <= ROUND;
        end
        ROUND: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= SIGN;
          if (in_range) begin
            valid_reg <= 1'b1;
            val_reg   <= res;
          end else begin
            ovf_reg <= 1'b1;
            if (SAT != 0) val_reg <= ovf_sat;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign valid = valid_reg;
  assign dbz   = dbz_reg;
  assign ovf   = ovf_reg;
  assign val   = val_reg;

endmodule

// File: doc/div_round_sat.md
Name: div_round_sat

Overview:
- Sequential fixed-point divider. Successor to the team's single-mode signed divider.
- Adds: runtime signed/unsigned selection, runtime rounding-mode selection, configurable iterations per clock (radix 2^STEPS) and optional saturation.
- Handles the most-negative input exactly instead of flagging overflow.
- Sits beside the other maths-library blocks; used by fixed-point datapaths that need a quotient with deterministic latency.

Parameters:
- WIDTH, 16, total operand/result width in bits (integer + fractional), >= 4
- FBITS, 8, fractional bits within WIDTH, 0..WIDTH-1
- STEPS, 1, quotient bits produced per clock, 1..8
- SAT, 1, 1 = saturate val on overflow/divide-by-zero, 0 = leave val unchanged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a division; sampled only when busy=0
- sgn  in  1  1 = operands and result are two's complement; 0 = unsigned; sampled with start
- rmode  in  2  rounding: 0 truncate toward zero, 1 round half to even, 2 round half away from zero, 3 treated as 1; sampled with start
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- busy  out  1  calculation in progress
- done  out  1  single-cycle pulse, calculation finished
- valid  out  1  val holds a correct, in-range result
- dbz  out  1  divide by zero
- ovf  out  1  result out of range
- val  out  WIDTH  quotient

Behaviour:
- Reset values (clk, rst synchronous, active-high): busy=0, done=0, valid=0, dbz=0, ovf=0, val=0, state=IDLE.
- rst wins over every other event, including mid-calculation: abort, no done pulse.
- start while busy=1 is ignored.

Accepting a request (IDLE with start=1):
- Register sgn, rmode and the operand magnitudes as WIDTH-bit unsigned values. abs(-2^(WIDTH-1)) = 2^(WIDTH-1) fits, so the minimum value is legal.
- Register the result sign: a_sign XOR b_sign, forced 0 when sgn=0.
- valid, dbz and ovf clear on acceptance.

Divide by zero (b==0):
- No calculation; busy stays 0.
- Next cycle: done=1, dbz=1, ovf=0, valid=0.
- If SAT=1, val = signed max when a >= 0, signed min when a < 0; unsigned max (all ones) when sgn=0.

Normal path, states IDLE -> INIT -> CALC -> ROUND -> SIGN -> IDLE:
- CALC performs restoring division on the magnitudes, STEPS iterations per clock.
- N = WIDTH+FBITS+1 total iterations: one guard bit beyond the result LSB.
- The final clock may use fewer than STEPS iterations.
- Quotient magnitude register is WIDTH+FBITS bits wide, so there is no early overflow exit.
- Latency is fixed: done asserts exactly 3 + ceil(N/STEPS) cycles after the start cycle.
- busy=1 from the cycle after start until done.

ROUND state (magnitude-based, so symmetric about zero):
- g = guard bit; s = sticky = (remainder != 0); L = result LSB.
- Mode 0: no change.
- Mode 1: increment if g AND (L OR s).
- Mode 2: increment if g.

SIGN state:
- Range check after rounding. Limit is 2^(WIDTH-1)-1 for positive signed results, 2^(WIDTH-1) for negative signed results, 2^WIDTH-1 for unsigned.
- In range: val = negated magnitude if the sign is set, else the magnitude; -0 yields 0. valid=1, ovf=0.
- Out of range: ovf=1, valid=0. If SAT=1, val = max/min for the result sign; else val is unchanged.
- done pulses for one cycle; busy drops in the same cycle.

Holding:
- Flags and val persist until the next accepted start or rst.
- start asserted in the done cycle is accepted (busy=0).

Test Plan:
- WIDTH=16, FBITS=8, sgn=1, rmode=0, STEPS=1: a=0x0300 (3.0), b=0x0200 (2.0) -> val=0x0180, valid=1, done exactly 28 cycles after start; with STEPS=4 done after 10 cycles.
- Rounding, b=0x0200, sgn=1:
  - a=0x0003 -> rmode 0/1/2 give 0x0001/0x0002/0x0002.
  - a=0x0001 -> 0x0000/0x0000/0x0001.
  - a=0xFFFD -> 0xFFFF/0xFFFE/0xFFFE.
- Extremes, sgn=1:
  - a=0x8000, b=0x0100 -> val=0x8000, valid=1, ovf=0.
  - a=0x8000, b=0xFF00 -> ovf=1, valid=0, val=0x7FFF (SAT=1) or previous val (SAT=0).
  - a=0x7FFF, b=0x0001, rmode=2 -> ovf=1 at the fixed latency.
- Unsigned, sgn=0: a=0xFF00, b=0x0200 -> val=0x7F80. a=0xFFFF, b=0x0080 -> ovf=1, val=0xFFFF (SAT=1).
- Divide by zero: a=0x0100, b=0 -> done 1 cycle after start, dbz=1, busy never 1, val=0x7FFF; a=0xFF00, b=0 -> val=0x8000.
- Control:
  - start pulsed mid-CALC is ignored; the first result is unchanged.
  - rst asserted mid-CALC -> all outputs 0 next cycle, no done.
  - Back-to-back start in the done cycle -> second result at the same latency.
